// File: rtl/bcd_serial_seq.sv
// bcd_serial_seq: serial BCD adder, one digit per clock from digit 0 upward.
// Optional BCD_SEQ_DIGIT_CHECK_EN adds a sticky invalid-digit flag on err.
module bcd_serial_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              r_state, w_next;
    logic [4*DIGITS-1:0] r_a, r_b, r_sum;
    logic [IW-1:0]       r_idx;
    logic                r_carry, r_cout;
    logic [3:0]          w_da, w_db, w_dig;
    logic [4:0]          w_t;
    logic                w_gt, w_last, w_accept;
    assign w_da     = r_a[{r_idx, 2'b00} +: 4];
    assign w_db     = r_b[{r_idx, 2'b00} +: 4];
    assign w_t      = {1'b0, w_da} + {1'b0, w_db} + {4'b0, r_carry};
    assign w_gt     = w_t > 5'd9;
    assign w_dig    = w_gt ? w_t[3:0] + 4'd6 : w_t[3:0];
    assign w_last   = r_idx == IW'(DIGITS - 1);
    assign w_accept = start && (r_state != RUN);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_idx   <= '0;
                r_sum   <= '0;
                r_cout  <= 1'b0;
            end else if (r_state == RUN) begin
                r_sum[{r_idx, 2'b00} +: 4] <= w_dig;
                r_carry <= w_gt;
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) r_cout <= w_gt;
            end
        end
    end
`ifdef BCD_SEQ_DIGIT_CHECK_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (rst || w_accept) r_err <= 1'b0;
        else if (r_state == RUN && (w_da > 4'd9 || w_db > 4'd9)) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif
    assign busy = r_state == RUN;
    assign done = r_state == DONE;
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_bcd_serial_seq.sv
// tb_bcd_serial_seq: directed and random checks of bcd_serial_seq against a decimal model.
module tb_bcd_serial_seq;
    localparam int DIGITS = 4;
    logic        clk, rst, start, cin, busy, done, cout, err;
    logic [15:0] a, b, sum;
    int          n_chk = 0, n_err = 0;

    bcd_serial_seq #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic wait_done(input string tag);
        int nb = 0;
        while (busy && nb < 20) begin
            check({tag, "_nodone"}, done, 0);
            nb++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, nb, DIGITS);
        check({tag, "_done"}, done, 1);
    endtask

    task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                      input logic tc, input logic [15:0] es, input logic ec, input logic ee);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; cin = tc;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        wait_done(tag);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_err"}, err, ee);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_sum_hold"}, sum, es);
        check({tag, "_cout_hold"}, cout, ec);
    endtask

    task automatic op_model(input string tag, input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        int total = bcd2int(ta) + bcd2int(tb) + int'(tc);
        op(tag, ta, tb, tc, int2bcd(total % 10000), total >= 10000, 1'b0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        bad_err;
`ifdef BCD_SEQ_DIGIT_CHECK_EN
        bad_err = 1'b1;
`else
        bad_err = 1'b0;
`endif
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        op_model("d0001", 16'h0001, 16'h0016, 1'b0);
        op("d0062", 16'h0062, 16'h0098, 1'b0, 16'h0160, 1'b0, 1'b0);
        op("d0017", 16'h0017, 16'h0024, 1'b1, 16'h0042, 1'b0, 1'b0);
        op("d9999c1", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        op("d9999c0", 16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0);

        // held start: second operation accepted in the DONE cycle
        @(negedge clk);
        start = 1'b1; a = 16'h0001; b = 16'h0016; cin = 1'b0;
        @(negedge clk);
        a = 16'h1111;
        wait_done("b2b_first");
        check("b2b_first_sum", sum, 16'h0017);
        @(negedge clk);
        start = 1'b0;
        check("b2b_rerun", busy, 1);
        wait_done("b2b_second");
        check("b2b_second_sum", sum, 16'h1127);
        check("b2b_second_cout", cout, 0);

        // reset lands on the edge that writes digit 2
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_err", err, 0);
        repeat (6) begin
            @(negedge clk);
            check("abort_nodone", done, 0);
        end
        op("d0049", 16'h0049, 16'h0049, 1'b1, 16'h0099, 1'b0, 1'b0);

        op("invalid", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, bad_err);
        op_model("after_invalid", 16'h0005, 16'h0005, 1'b0);

        for (int k = 0; k < 40; k++) begin
            for (int d = 0; d < DIGITS; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(0, 9));
                rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            op_model("rand", ra, rb, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bcd_serial_seq.md
BCD_SERIAL_SEQ -- requirements
Module: bcd_serial_seq

Interface
REQ-001 Parameter: DIGITS, 4, number of BCD digits per operand (range 1..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled on clk rising edge.
REQ-005 Port: a  input  4*DIGITS  BCD operand A, digit 0 in bits [3:0].
REQ-006 Port: b  input  4*DIGITS  BCD operand B, same digit layout as a.
REQ-007 Port: cin  input  1  carry into digit 0.
REQ-008 Port: busy  output  1  high while the operation is in progress (state RUN).
REQ-009 Port: done  output  1  one-cycle pulse; sum/cout/err final.
REQ-010 Port: sum  output  4*DIGITS  BCD result, one digit written per RUN cycle.
REQ-011 Port: cout  output  1  carry out of digit DIGITS-1.
REQ-012 Port: err  output  1  invalid-digit flag (see Configuration).

Function
REQ-013 FSM SHALL have states IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE or DONE with start=1 at an edge: latch a, b, cin; clear sum, cout, err; digit index=0; go RUN.
REQ-015 IDLE with start=0 stays IDLE; DONE with start=0 goes IDLE.
REQ-016 RUN, each edge: t = a[i] + b[i] + carry (5-bit); if t>9 then digit=(t+6) mod 16, carry=1, else digit=t, carry=0; write digit into sum[i]; index+1.
REQ-017 RUN at index DIGITS-1: write last digit, load cout with final carry, go DONE.
REQ-018 Latency: start sampled at edge t -> digit i written at edge t+1+i; done=1 for exactly the cycle between edges t+DIGITS and t+DIGITS+1.
REQ-019 busy=1 exactly while state=RUN; done=1 exactly while state=DONE.
REQ-020 start while RUN SHALL be ignored; latched operands SHALL NOT change mid-operation.
REQ-021 a, b, cin SHALL only be sampled at the accepting edge; later changes have no effect.
REQ-022 sum, cout, err SHALL hold their final values after DONE until the next accepted start.
REQ-023 Back-to-back: start=1 during DONE SHALL be accepted with no idle cycle.
REQ-024 sum contents during RUN are partial and not guaranteed to the user.

Reset
REQ-025 rst=1 at an edge: state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, index=0, carry=0, latched operands=0.
REQ-026 rst SHALL dominate start; rst during RUN aborts, no done pulse is produced.
REQ-027 First start after rst deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro BCD_SEQ_DIGIT_CHECK_EN defined: err SHALL be set at any RUN edge where a[i]>9 or b[i]>9; sticky until next accepted start or rst; valid with done.
REQ-029 Macro BCD_SEQ_DIGIT_CHECK_EN undefined: err SHALL be constant 0; port still present.
REQ-030 Arithmetic per REQ-016 SHALL be identical with and without the macro (invalid digits still processed).

Verification (DIGITS=4)
REQ-031 start with a=0x0001, b=0x0016, cin=0 -> done 4 edges after start edge; sum=0x0017, cout=0, busy high for 4 cycles.
REQ-032 a=0x0062, b=0x0098, cin=0 -> sum=0x0160, cout=0; a=0x0017, b=0x0024, cin=1 -> sum=0x0042, cout=0.
REQ-033 a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1; cin=0 -> sum=0x9998, cout=1.
REQ-034 start held high with a changing to 0x1111 during RUN -> result of first operands only; second start taken in DONE cycle, second result follows 4 edges later.
REQ-035 rst pulse on the edge writing digit 2 -> all outputs 0 next cycle, no done; following start a=0x0049, b=0x0049, cin=1 -> sum=0x0099.
REQ-036 a=0x00A0, b=0x0000: with BCD_SEQ_DIGIT_CHECK_EN err=1 at done; without it err=0; sum identical in both builds.
